dt_img_loader: RTL and testbench
================================

Name: dt_img_loader

Overview:
- Producer side of the DT stimulus memory: accepts a raster stream of 8-bit grayscale pixels, binarizes against a threshold, packs 16 pixels per word MSB-first, and writes the 1024-word binary image into sti memory.
- Holds the DT core in reset until a complete frame is stored, then releases it.
- Bit ordering is fixed: the first pixel of each word occupies bit 15, matching the DT core's read order.

Parameters:
- IMG_W, 128, pixels per row.
- IMG_H, 128, rows per frame.
- WORD_W, 16, pixels per sti word; total words = IMG_W*IMG_H/WORD_W = 1024.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: arm a new frame load.
- thresh  in  8  binarization threshold, sampled on start.
- in_valid  in  1  pixel valid.
- in_ready  out  1  loader accepts a pixel this cycle.
- in_sof  in  1  marks the first pixel of a frame.
- in_pix  in  8  grayscale pixel.
- sti_wr  out  1  sti memory write strobe, one cycle per word.
- sti_addr  out  10  word address.
- sti_do  out  16  packed binary word.
- load_done  out  1  frame fully written, level.
- err_sof  out  1  sticky: in_sof seen mid-frame.
- dt_reset  out  1  active-low reset to DT core.

Behaviour:
- Reset values: in_ready=0, sti_wr=0, sti_addr=0, sti_do=0, load_done=0, err_sof=0, dt_reset=0. State=IDLE, pix_cnt=0 (14 bit), shift register=0, thr_q=0.
- FSM states: IDLE, SYNC, PACK, FLUSH, DONE.
- IDLE: in_ready=0. On start: thr_q<=thresh, clear counters and err_sof, go to SYNC. dt_reset stays 0.
- SYNC: in_ready=1. Accepted beats (in_valid&in_ready) with in_sof=0 are dropped and not counted. A beat with in_sof=1 is pixel 0; go to PACK.
- PACK: in_ready=1.
  - Each accepted pixel: bit = (in_pix >= thr_q), stored at bit 15-pix_cnt[3:0]; pix_cnt++.
  - When pix_cnt[3:0]==15 is accepted, the full word moves to a hold register. Next cycle: sti_wr=1, sti_addr=pix_cnt[13:4] of that word, sti_do=word, for exactly one cycle.
  - Packing continues without stall; in_ready is never deasserted in PACK.
- Mid-frame in_sof=1 on an accepted beat in PACK with pix_cnt!=0:
  - err_sof<=1.
  - The partial word is discarded; the beat is pixel 0 of a new frame.
  - Words already written are not cleared.
- Last pixel (pix_cnt==16383) accepted: go to FLUSH; in_ready=0 from the next cycle.
- FLUSH: the final word write occurs (sti_wr=1, sti_addr=1023). Next cycle go to DONE.
- DONE: load_done=1 and dt_reset=1, both asserted in the cycle after the last write strobe. in_ready=0; input beats are ignored.
- start in DONE: load_done=0 and dt_reset=0 next cycle, go to SYNC. start in SYNC/PACK/FLUSH is ignored.
- Threshold arithmetic: unsigned 8-bit compare. thresh=0 makes every pixel 1.
- Reset asserted mid-operation: all outputs return to reset values immediately; no partial write is completed.
- Latency: accepted pixel to its word write is 1 cycle after that word's 16th pixel.

Optional Feature:
- Macro: DT_LOADER_BORDER_CLR_EN.
- Defined: pixels in row 0, row IMG_H-1, column 0 or column IMG_W-1 are forced to 0 regardless of threshold. This guarantees the DT border precondition. Row = pix_cnt[13:7], col = pix_cnt[6:0].
- Undefined: every pixel is thresholded uniformly.

Decomposition:
- Package dt_pkg:
  - constants IMG_W, IMG_H, WORD_W, STI_WORDS=1024, STI_AW=10, RES_AW=14.
  - state enum typedef loader_state_t {IDLE,SYNC,PACK,FLUSH,DONE}.
- One sub-module, dt_bit_packer: a 16-bit MSB-first shift/pack register with word-complete flag and hold register. The FSM, counters and handshake stay in the top.

Test Plan:
- All 16384 pixels=200, thresh=128, sof on first beat:
  - 1024 sti_wr pulses, every sti_do=16'hFFFF, addresses 0..1023 in order.
  - load_done and dt_reset rise 1 cycle after the addr-1023 write.
- Word 0 pixels alternating 255/0, thresh=1: first write sti_addr=0, sti_do=16'hAAAA (bit15=first pixel).
- In SYNC, 5 beats with sof=0 then a sof frame of all 255: the dropped beats produce no writes; exactly 1024 writes follow.
- sof asserted again at pixel 40 of a frame:
  - err_sof=1 and stays 1.
  - Word-address restarts at 0; 1024 further writes complete; load_done=1.
- reset driven low while pix_cnt=5000: the same cycle sti_wr=0, dt_reset=0, in_ready=0; after release the FSM is in IDLE.
- With DT_LOADER_BORDER_CLR_EN, all pixels 255, thresh=0:
  - Word 0 = 16'h0000.
  - Word 8 (row 1, cols 0-15) = 16'h7FFF.
  - Word 15 (row 1, cols 112-127) = 16'hFFFE.
  - Word 1023 = 16'h0000.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared constants, state encoding and pixel-geometry helper for the DT image loader.
package dt_pkg;

    localparam int unsigned IMG_W     = 128;
    localparam int unsigned IMG_H     = 128;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned STI_WORDS = IMG_W * IMG_H / WORD_W;
    localparam int unsigned STI_AW    = 10;
    localparam int unsigned RES_AW    = 14;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned POS_W     = 4;
    localparam int unsigned COL_W     = 7;
    localparam int unsigned ROW_W     = RES_AW - COL_W;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PACK,
        FLUSH,
        DONE
    } loader_state_t;

    // True when the raster index lies on the outermost row or column of the frame.
    function automatic logic is_border(input logic [RES_AW-1:0] idx);
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        row = idx[RES_AW-1:COL_W];
        col = idx[COL_W-1:0];
        return (row == '0) || (row == ROW_W'(IMG_H - 1)) ||
               (col == '0) || (col == COL_W'(IMG_W - 1));
    endfunction

endpackage

// File: rtl/dt_bit_packer.sv
// MSB-first 16-pixel binary packer: the pixel at position 0 lands in bit 15.
// A completed word moves to a hold register and word_vld pulses for one cycle.
module dt_bit_packer
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clr,
    input  logic [POS_W-1:0]  pos,
    input  logic              pix_bit,
    output logic              word_vld,
    output logic [WORD_W-1:0] word
);

    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] next_c;
    logic [POS_W-1:0]  bit_idx_c;

    // clr discards the partial word so a restarted frame begins from an empty register
    always_comb begin
        bit_idx_c         = POS_W'(WORD_W - 1) - pos;
        next_c            = clr ? '0 : shift_q;
        next_c[bit_idx_c] = pix_bit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q  <= '0;
            word     <= '0;
            word_vld <= 1'b0;
        end else begin
            word_vld <= 1'b0;
            if (load) begin
                if (pos == POS_W'(WORD_W - 1)) begin
                    word     <= next_c;
                    word_vld <= 1'b1;
                    shift_q  <= '0;
                end else begin
                    shift_q  <= next_c;
                end
            end
        end
    end

endmodule

// File: rtl/dt_img_loader.sv
// Streams a grayscale raster into the DT sti memory as packed binary words, then releases the DT core.
// Optional DT_LOADER_BORDER_CLR_EN forces the outer frame border to 0.
module dt_img_loader
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PIX_W-1:0]  thresh,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [PIX_W-1:0]  in_pix,
    output logic              sti_wr,
    output logic [STI_AW-1:0] sti_addr,
    output logic [WORD_W-1:0] sti_do,
    output logic              load_done,
    output logic              err_sof,
    output logic              dt_reset
);

    localparam logic [RES_AW-1:0] LAST_PIX = RES_AW'(IMG_W * IMG_H - 1);

    loader_state_t     state;
    logic [RES_AW-1:0] pix_cnt;
    logic [PIX_W-1:0]  thr_q;

    logic              take_c;
    logic              restart_c;
    logic              load_c;
    logic [RES_AW-1:0] idx_c;
    logic [POS_W-1:0]  pos_c;
    logic              bit_c;

    // A sof beat is always pixel 0, whether it opens the frame or restarts it mid-stream
    always_comb begin
        take_c    = in_valid && in_ready && ((state == SYNC) || (state == PACK));
        restart_c = take_c && in_sof;
        load_c    = take_c && ((state == PACK) || in_sof);
        idx_c     = restart_c ? '0 : pix_cnt;
        pos_c     = idx_c[POS_W-1:0];
`ifdef DT_LOADER_BORDER_CLR_EN
        bit_c     = (in_pix >= thr_q) && !is_border(idx_c);
`else
        bit_c     = (in_pix >= thr_q);
`endif
    end

    dt_bit_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_c),
        .clr      (restart_c),
        .pos      (pos_c),
        .pix_bit  (bit_c),
        .word_vld (sti_wr),
        .word     (sti_do)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            thr_q     <= '0;
            in_ready  <= 1'b0;
            sti_addr  <= '0;
            load_done <= 1'b0;
            err_sof   <= 1'b0;
            dt_reset  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        thr_q     <= thresh;
                        pix_cnt   <= '0;
                        err_sof   <= 1'b0;
                        load_done <= 1'b0;
                        dt_reset  <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= SYNC;
                    end
                end
                SYNC: begin
                    if (restart_c) begin
                        pix_cnt <= RES_AW'(1);
                        state   <= PACK;
                    end
                end
                PACK: begin
                    if (take_c) begin
                        if (in_sof) begin
                            pix_cnt <= RES_AW'(1);
                            if (pix_cnt != '0) begin
                                err_sof <= 1'b1;
                            end
                        end else begin
                            pix_cnt <= pix_cnt + RES_AW'(1);
                            if (pos_c == POS_W'(WORD_W - 1)) begin
                                sti_addr <= pix_cnt[RES_AW-1:POS_W];
                            end
                            if (pix_cnt == LAST_PIX) begin
                                in_ready <= 1'b0;
                                state    <= FLUSH;
                            end
                        end
                    end
                end
                // The final word strobes during this state; release the core right after it
                FLUSH: begin
                    load_done <= 1'b1;
                    dt_reset  <= 1'b1;
                    state     <= DONE;
                end
                default: begin
                    in_ready <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dt_img_loader.sv
// Directed self-checking bench for dt_img_loader; honours DT_LOADER_BORDER_CLR_EN in its expectations.
module tb_dt_img_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  thresh;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [7:0]  in_pix;
    logic        sti_wr;
    logic [9:0]  sti_addr;
    logic [15:0] sti_do;
    logic        load_done;
    logic        err_sof;
    logic        dt_reset;

    int vectors;
    int miscompares;

    logic [9:0]  wa_q[$];
    logic [15:0] wd_q[$];

    dt_img_loader dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .thresh    (thresh),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_pix    (in_pix),
        .sti_wr    (sti_wr),
        .sti_addr  (sti_addr),
        .sti_do    (sti_do),
        .load_done (load_done),
        .err_sof   (err_sof),
        .dt_reset  (dt_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write strobe mid-cycle for later comparison
    always @(negedge clk) begin
        if (rst_n && sti_wr) begin
            wa_q.push_back(sti_addr);
            wd_q.push_back(sti_do);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic sof, input logic [7:0] pix);
        in_valid = 1'b1;
        in_sof   = sof;
        in_pix   = pix;
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] th);
        start  = 1'b1;
        thresh = th;
        step();
        start  = 1'b0;
    endtask

    // Expected word for the thresh=0 frame: all ones unless the border is cleared
    function automatic logic [15:0] exp_zero_thr(input int w);
        logic [15:0] r;
        r = 16'hFFFF;
`ifdef DT_LOADER_BORDER_CLR_EN
        for (int j = 0; j < 16; j++) begin
            int k;
            int row;
            int col;
            k   = 16 * w + j;
            row = k / 128;
            col = k % 128;
            if (row == 0 || row == 127 || col == 0 || col == 127) r[15-j] = 1'b0;
        end
`endif
        return r;
    endfunction

    // Expected word for the ramp frame at thresh=1: only pixel values of 0 binarize to 0
    function automatic logic [15:0] exp_ramp(input int w);
        return (w % 16 == 0) ? 16'h7FFF : 16'hFFFF;
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        thresh      = 8'd0;
        in_valid    = 1'b0;
        in_sof      = 1'b0;
        in_pix      = 8'd0;

        repeat (2) step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_sti_wr", 32'(sti_wr), 32'd0);
        chk("rst_sti_addr", 32'(sti_addr), 32'd0);
        chk("rst_sti_do", 32'(sti_do), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_err_sof", 32'(err_sof), 32'd0);
        chk("rst_dt_reset", 32'(dt_reset), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // Frame A: five non-sof beats dropped in SYNC, then a uniform 200 frame at thresh 128
        pulse_start(8'd128);
        chk("a_sync_ready", 32'(in_ready), 32'd1);
        wa_q.delete();
        wd_q.delete();
        for (int k = 0; k < 5; k++) feed(1'b0, 8'd200);
        chk("a_drop_nowr", 32'(wa_q.size()), 32'd0);
        feed(1'b1, 8'd200);
        for (int k = 1; k < 16384; k++) feed(1'b0, 8'd200);
        chk("a_last_wr", 32'(sti_wr), 32'd1);
        chk("a_last_addr", 32'(sti_addr), 32'd1023);
        chk("a_flush_ready", 32'(in_ready), 32'd0);
        chk("a_flush_done", 32'(load_done), 32'd0);
        chk("a_flush_dtrst", 32'(dt_reset), 32'd0);
        step();
        chk("a_done", 32'(load_done), 32'd1);
        chk("a_dt_reset", 32'(dt_reset), 32'd1);
        chk("a_done_wr", 32'(sti_wr), 32'd0);
        chk("a_nwrites", 32'(wa_q.size()), 32'd1024);
        for (int i = 0; i < 1024 && i < wa_q.size(); i++) begin
            chk("a_addr", 32'(wa_q[i]), 32'(i));
            chk("a_data", 32'(wd_q[i]), 32'h0000FFFF);
        end
        for (int k = 0; k < 3; k++) feed(1'b1, 8'd200);
        chk("a_done_ignore", 32'(wa_q.size()), 32'd1024);
        chk("a_done_ready", 32'(in_ready), 32'd0);
        chk("a_done_hold", 32'(load_done), 32'd1);

        // Frame B: alternating 255/0 at thresh 1, sof restart at pixel 40, then a ramp frame
        pulse_start(8'd1);
        chk("b_start_done", 32'(load_done), 32'd0);
        chk("b_start_dtrst", 32'(dt_reset), 32'd0);
        chk("b_start_ready", 32'(in_ready), 32'd1);
        wa_q.delete();
        wd_q.delete();
        for (int k = 0; k < 40; k++) feed(k == 0, (k % 2 == 0) ? 8'hFF : 8'h00);
        chk("b_err_clear", 32'(err_sof), 32'd0);
        feed(1'b1, 8'd0);
        chk("b_err_set", 32'(err_sof), 32'd1);
        for (int k = 1; k < 16384; k++) feed(1'b0, 8'(k));
        chk("b_last_addr", 32'(sti_addr), 32'd1023);
        step();
        chk("b_done", 32'(load_done), 32'd1);
        chk("b_err_sticky", 32'(err_sof), 32'd1);
        chk("b_nwrites", 32'(wa_q.size()), 32'd1026);
        if (wa_q.size() >= 2) begin
            chk("b_w0_addr", 32'(wa_q[0]), 32'd0);
            chk("b_w0_data", 32'(wd_q[0]), 32'h0000AAAA);
            chk("b_w1_addr", 32'(wa_q[1]), 32'd1);
            chk("b_w1_data", 32'(wd_q[1]), 32'h0000AAAA);
        end
        for (int i = 0; i < 1024 && i + 2 < wa_q.size(); i++) begin
            chk("b_addr", 32'(wa_q[i+2]), 32'(i));
            chk("b_data", 32'(wd_q[i+2]), 32'(exp_ramp(i)));
        end

        // Frame C: thresh 0 with all-zero pixels; a start pulse mid-frame must be ignored
        pulse_start(8'd0);
        wa_q.delete();
        wd_q.delete();
        feed(1'b1, 8'd0);
        for (int k = 1; k < 16384; k++) begin
            if (k == 100) begin
                start  = 1'b1;
                thresh = 8'd255;
                feed(1'b0, 8'd0);
                start  = 1'b0;
                thresh = 8'd0;
            end else begin
                feed(1'b0, 8'd0);
            end
        end
        step();
        chk("c_done", 32'(load_done), 32'd1);
        chk("c_nwrites", 32'(wa_q.size()), 32'd1024);
        for (int i = 0; i < 1024 && i < wa_q.size(); i++) begin
            chk("c_addr", 32'(wa_q[i]), 32'(i));
            chk("c_data", 32'(wd_q[i]), 32'(exp_zero_thr(i)));
        end

        // Asynchronous reset with pix_cnt at 5000
        pulse_start(8'd128);
        feed(1'b1, 8'd77);
        for (int k = 1; k < 5000; k++) feed(1'b0, 8'd77);
        chk("r_pre_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("r_in_ready", 32'(in_ready), 32'd0);
        chk("r_sti_wr", 32'(sti_wr), 32'd0);
        chk("r_dt_reset", 32'(dt_reset), 32'd0);
        chk("r_sti_addr", 32'(sti_addr), 32'd0);
        in_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        wa_q.delete();
        wd_q.delete();
        for (int k = 0; k < 4; k++) feed(1'b1, 8'd255);
        chk("r_idle_ready", 32'(in_ready), 32'd0);
        chk("r_idle_nowr", 32'(wa_q.size()), 32'd0);
        chk("r_idle_done", 32'(load_done), 32'd0);
        pulse_start(8'd128);
        chk("r_restart_ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
